// File: rtl/sw_debounce_sync.sv
// -----------------------------------------------------------------------------
// sw_debounce_sync
//
// Conditions the raw board switches before the processor's SW port. Each bit
// is brought into clk through a two-flop synchronizer, then debounced: a new
// level is accepted only after the synchronized input has differed from the
// current stable level for DEBOUNCE_CYCLES consecutive clock edges. Accepted
// changes produce a one-cycle event pulse and set a sticky per-bit flag that
// software clears through clr_en/clr_mask.
//
// Ports
//   clk          system clock, all state on the rising edge
//   RST_n        asynchronous active-low reset
//   sw_raw       raw, asynchronous, bouncing switch levels
//   sw_stable    debounced, synchronized switch levels
//   sw_event     one-cycle pulse per bit in the cycle after a level is accepted
//   sw_changed   sticky per-bit change flags
//   chg_pending  OR of sw_changed (combinational, no extra latency)
//   clr_en       clear strobe for the sticky flags
//   clr_mask     which sticky flags to clear when clr_en is high
// -----------------------------------------------------------------------------
module sw_debounce_sync #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_event,
  output logic [WIDTH-1:0] sw_changed,
  output logic             chg_pending,
  input  logic             clr_en,
  input  logic [WIDTH-1:0] clr_mask
);

  // Terminal count: the D-th consecutive differing edge is the one that
  // accepts, so the counter only ever needs to reach D-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] event_q;
  logic [WIDTH-1:0] changed_q;
  logic [WIDTH-1:0] changed_d;
  logic [WIDTH-1:0] accept_d;
  logic [WIDTH-1:0] clear_d;

  // ---------------------------------------------------------------------------
  // Per-bit stability counters. Each bit is completely independent.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differs;

    assign differs       = (sync2_q[gi] != stable_q[gi]);
    assign accept_d[gi]  = differs && (cnt_q == CNT_LAST);

    // Any return to the stable level, or an acceptance, restarts the count.
    assign cnt_d = (!differs || (cnt_q == CNT_LAST)) ? '0
                                                     : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stable level, sticky flags.
  // ---------------------------------------------------------------------------
  // An accepted bit always takes the opposite of its current stable value.
  assign stable_d = stable_q ^ accept_d;

  // Clear first, then OR in new acceptances so a same-cycle set wins.
  assign clear_d   = clr_en ? clr_mask : '0;
  assign changed_d = (changed_q & ~clear_d) | accept_d;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      event_q   <= '0;
      changed_q <= '0;
    end else begin
      sync1_q   <= sw_raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      event_q   <= accept_d;
      changed_q <= changed_d;
    end
  end

  assign sw_stable   = stable_q;
  assign sw_event    = event_q;
  assign sw_changed  = changed_q;
  assign chg_pending = |changed_q;

endmodule
